// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared response codes and FSM encoding for the RAM initiator
package ram_master_pkg;

  // Completion status returned to the CPU with resp_valid
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BUS_EXC = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_RANGE   = 2'b11
  } resp_err_e;

  // One transaction in flight: pick a strobe, wait for the RAM, pulse the response
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

endpackage

// File: rtl/ram_master_if.sv
// rtl/ram_master_if.sv - single-word RAM port between the initiator and the ram block
interface ram_master_if;
  logic        read;
  logic        write;
  logic [31:0] r_addr;
  logic [31:0] w_addr;
  logic [31:0] w_line;
  logic [31:0] r_line;
  logic        rrdy;
  logic        wrdy;
  logic        exc;

  modport master (
    output read, write, r_addr, w_addr, w_line,
    input  r_line, rrdy, wrdy, exc
  );

  modport slave (
    input  read, write, r_addr, w_addr, w_line,
    output r_line, rrdy, wrdy, exc
  );
endinterface

// File: rtl/ram_master.sv
// rtl/ram_master.sv - CPU load/store initiator with range check, stale-status mask and timeout
module ram_master
  import ram_master_pkg::*;
#(
  parameter int MEM_WORDS = 262144,
  parameter int TIMEOUT   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic [1:0]   resp_err,
  ram_master_if.master ram
);

  localparam int CW = $clog2(TIMEOUT);

  state_e      state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [31:0] w_line_q, w_line_d;
  logic [31:0] rdata_q, rdata_d;
  resp_err_e   err_q, err_d;
  logic        rdy;

  // State register plus the strobe/capture registers; reset drops strobes immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_line_q <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      read_q   <= read_d;
      write_q  <= write_d;
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      w_line_q <= w_line_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next state: the first wait cycle ignores rrdy/wrdy/exc left over from the previous access
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    read_d   = read_q;
    write_d  = write_q;
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    w_line_d = w_line_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rdy      = (state_q == ST_RD_WAIT) ? ram.rrdy : ram.wrdy;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wait_d = '0;
          if (req_we) begin
            w_addr_d = req_addr;
            w_line_d = req_wdata;
          end else begin
            r_addr_d = req_addr;
          end
          if (req_addr >= 32'(MEM_WORDS)) begin
            err_d   = ERR_RANGE;
            rdata_d = '0;
            state_d = ST_RESP;
          end else if (req_we) begin
            write_d = 1'b1;
            state_d = ST_WR_WAIT;
          end else begin
            read_d  = 1'b1;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (wait_q == '0) begin
          wait_d = wait_q + CW'(1);
        end else if (rdy) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = (state_q == ST_RD_WAIT) ? ram.r_line : '0;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (ram.exc) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = '0;
          err_d   = ERR_BUS_EXC;
          state_d = ST_RESP;
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign ram.read   = read_q;
  assign ram.write  = write_q;
  assign ram.r_addr = r_addr_q;
  assign ram.w_addr = w_addr_q;
  assign ram.w_line = w_line_q;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - scoreboard bench for ram_master against a latency-programmable RAM stub
module tb_ram_master;
  import ram_master_pkg::*;

  localparam int MW      = 1024;
  localparam int EXC_LO  = 1000;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  always #5 clk = ~clk;

  ram_master_if ram_if();

  ram_master #(.MEM_WORDS(MW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram        (ram_if.master)
  );

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem [MW];
  logic [31:0] ram_mem [MW];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // RAM stub: each new strobe pops a latency L; the response is driven L edges after it is seen
  logic        st_busy = 1'b0;
  logic        st_done = 1'b0;
  int          st_cnt = 0;
  int          st_lat = 0;
  logic [31:0] st_addr = '0;

  task automatic respond(input logic [31:0] a);
    st_busy <= 1'b0;
    st_done <= 1'b1;
    if (a >= EXC_LO) begin
      ram_if.exc <= 1'b1;
    end else if (ram_if.write) begin
      ram_mem[a[9:0]] <= ram_if.w_line;
      ram_if.wrdy <= 1'b1;
    end else begin
      ram_if.r_line <= ram_mem[a[9:0]];
      ram_if.rrdy <= 1'b1;
    end
  endtask

  always @(posedge clk) begin
    logic        strobe;
    logic [31:0] a;
    int          l;
    strobe = ram_if.read | ram_if.write;
    a = st_busy ? st_addr : (ram_if.write ? ram_if.w_addr : ram_if.r_addr);
    ram_if.rrdy <= 1'b0;
    ram_if.wrdy <= 1'b0;
    if (!strobe) begin
      st_busy <= 1'b0;
      st_done <= 1'b0;
    end else if (!st_busy && !st_done) begin
      l = (lat_q.size() != 0) ? lat_q.pop_front() : 1000;
      ram_if.exc <= 1'b0;
      st_busy <= 1'b1;
      st_cnt  <= 1;
      st_lat  <= l;
      st_addr <= a;
      if (l == 1) respond(a);
    end else if (st_busy) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == st_lat) respond(a);
    end
  end

  // Strobe exclusivity whenever either strobe is active
  always @(negedge clk) begin
    if (ram_if.read || ram_if.write)
      check("strobe_exclusive", 32'(ram_if.read & ram_if.write), 32'h0);
  end

  // Monitor: every response pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got err %0d, required no response", resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_latency", 32'(edge_cnt - e.acc), 32'(e.lat));
        check("strobes_low_at_resp", 32'({ram_if.read, ram_if.write}), 32'h0);
      end
    end
  end

  // Reference: range first, then latency beyond the timeout window, then exception region
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input logic hold, output int acc);
    exp_t e;
    int   guard;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_wait: got 0 after %0d cycles, required 1", guard);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = edge_cnt + 1;
    if (addr >= MW) begin
      e = '{ERR_RANGE, 32'h0, acc, 0};
    end else begin
      lat_q.push_back(lat);
      if (lat > TMO - 1)      e = '{ERR_TIMEOUT, 32'h0, acc, TMO};
      else if (addr >= EXC_LO) e = '{ERR_BUS_EXC, 32'h0, acc, lat + 1};
      else if (we) begin
        ref_mem[addr[9:0]] = data;
        e = '{ERR_OK, 32'h0, acc, lat + 1};
      end else begin
        e = '{ERR_OK, ref_mem[addr[9:0]], acc, lat + 1};
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int prev;
    int g;
    for (int i = 0; i < MW; i++) begin
      ref_mem[i] = '0;
      ram_mem[i] = '0;
    end
    ram_if.rrdy   = 1'b0;
    ram_if.wrdy   = 1'b0;
    ram_if.exc    = 1'b0;
    ram_if.r_line = '0;

    repeat (3) @(negedge clk);
    check("rst_read", 32'(ram_if.read), 32'h0);
    check("rst_write", 32'(ram_if.write), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_r_addr", ram_if.r_addr, 32'h0);
    check("rst_w_addr", ram_if.w_addr, 32'h0);
    check("rst_w_line", ram_if.w_line, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);

    issue(1'b1, 32'd5, 32'hDEADBEEF, 1, 1'b0, acc);
    issue(1'b0, 32'd5, 32'h0, 1, 1'b0, acc);
    issue(1'b0, 32'h400, 32'h0, 1, 1'b0, acc);
    issue(1'b0, 32'd1010, 32'h0, 1, 1'b0, acc);
    issue(1'b1, 32'd1005, 32'hCAFE0001, 3, 1'b0, acc);
    issue(1'b0, 32'd5, 32'h0, 1, 1'b0, acc);
    issue(1'b0, 32'd20, 32'h0, 40, 1'b0, acc);
    issue(1'b0, 32'd20, 32'h0, 16, 1'b0, acc);
    issue(1'b0, 32'd5, 32'h0, 15, 1'b0, acc);
    issue(1'b1, 32'd7, 32'h12345678, 2, 1'b0, acc);

    issue(1'b0, 32'd7, 32'h0, 30, 1'b0, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("midrst_read", 32'(ram_if.read), 32'h0);
    check("midrst_resp_valid", 32'(resp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'd7, 32'h0, 2, 1'b0, acc);

    prev = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 32'(i * 3), 32'h0, 1, 1'b1, acc);
      if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    req_valid = 1'b0;

    for (int i = 0; i < 80; i++) begin
      int          r;
      int          p;
      int          lat;
      logic [31:0] addr;
      r = $urandom_range(0, 9);
      p = $urandom_range(0, 9);
      if (r == 0)      addr = 32'(MW + $urandom_range(0, 5000));
      else if (r == 1) addr = 32'(EXC_LO + $urandom_range(0, 23));
      else             addr = 32'($urandom_range(0, 63));
      if (p == 0)      lat = $urandom_range(17, 22);
      else if (p == 1) lat = $urandom_range(5, 15);
      else             lat = $urandom_range(1, 4);
      issue(1'($urandom_range(0, 1)), addr, $urandom, lat, 1'($urandom_range(0, 1)), acc);
    end
    req_valid = 1'b0;

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
